instruction_fetch_unit: RTL and testbench

Front-end fetch stage of the single-issue RV32I core. It owns the program counter and drives it to the byte-addressed, combinational instruction memory, then captures the returned instruction into the IF/ID pipeline register. It supports decode-side stalls, execute-side branch/jump redirects and a halting fetch fault on misaligned or out-of-range PCs. Downstream consumers are the decoder and the register-file read stage.

---
 rtl/instruction_fetch_unit.sv | 105 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, reads combinational instruction memory and fills the IF/ID register.
// Supports decode stalls, execute redirects and a sticky halt on misaligned or out-of-range fetch addresses.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned IMEM_LAST = 1240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instruction_code,
    output logic [31:0] pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instruction,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [32:0] LAST_ADDR = 33'(IMEM_LAST);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [31:0] fpc_q, fpc_d;

    // Widened to 33 bits so a PC near 2^32 cannot wrap past the range check.
    function automatic logic fetch_bad(input logic [31:0] addr);
        logic [32:0] last_byte;
        last_byte = {1'b0, addr} + 33'd3;
        return (addr[1:0] != 2'b00) || (last_byte > LAST_ADDR);
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vld_d   = vld_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        instr_d = instr_q;
        fault_d = fault_q;
        fpc_d   = fpc_q;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (redirect_valid) begin
                    pc_d  = redirect_target;
                    vld_d = 1'b0;
                end else if (fetch_bad(pc_q)) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                    fpc_d   = pc_q;
                    vld_d   = 1'b0;
                end else if (!stall) begin
                    ifpc_d  = pc_q;
                    ifpc4_d = pc_q + 32'd4;
                    instr_d = instruction_code;
                    vld_d   = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
            HALT: vld_d = 1'b0;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            ifpc_q  <= 32'd0;
            ifpc4_q <= 32'd0;
            instr_q <= 32'd0;
            fault_q <= 1'b0;
            fpc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            fpc_q   <= fpc_d;
        end
    end

    assign pc                = pc_q;
    assign if_id_valid       = vld_q;
    assign if_id_pc          = ifpc_q;
    assign if_id_pc_plus4    = ifpc4_q;
    assign if_id_instruction = instr_q;
    assign fetch_fault       = fault_q;
    assign fault_pc          = fpc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a vector table for the main run plus
// hand-written sequences for reset-from-halt, misaligned redirect and the range boundary.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instruction_code;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instruction;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int checks;
    int failures;

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IMEM_LAST(1240)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .instruction_code (instruction_code),
        .pc               (pc),
        .if_id_valid      (if_id_valid),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_instruction(if_id_instruction),
        .fetch_fault      (fetch_fault),
        .fault_pc         (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory model.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_12B7;
            32'h0000_0004: return 32'h00C2_D293;
            32'h0000_0020: return 32'hFE9F_F0EF;
            default:       return {a[23:0], 8'h13};
        endcase
    endfunction

    assign instruction_code = imem(pc);

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        vld;
        logic        chk_if;
        logic [31:0] ifpc;
        logic [31:0] ifpc4;
        logic [31:0] instr;
        logic        fault;
        logic [31:0] fpc;
    } vec_t;

    vec_t vec[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_vld"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, "_ifpc"}, if_id_pc, 32'h0);
        chk({tag, "_ifpc4"}, if_id_pc_plus4, 32'h0);
        chk({tag, "_instr"}, if_id_instruction, 32'h0);
        chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
        chk({tag, "_fpc"}, fault_pc, 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        //          stall rv  tgt        pc         vld chk ifpc       ifpc4      instr              fault fpc
        vec[0]  = '{1'b0, 1'b0, 32'h0,   32'h0,     1'b0, 1'b1, 32'h0,   32'h0,   32'h0,           1'b0, 32'h0};
        vec[1]  = '{1'b0, 1'b0, 32'h0,   32'h4,     1'b1, 1'b1, 32'h0,   32'h4,   32'h0000_12B7,   1'b0, 32'h0};
        vec[2]  = '{1'b0, 1'b0, 32'h0,   32'h8,     1'b1, 1'b1, 32'h4,   32'h8,   32'h00C2_D293,   1'b0, 32'h0};
        vec[3]  = '{1'b1, 1'b0, 32'h0,   32'h8,     1'b1, 1'b1, 32'h4,   32'h8,   32'h00C2_D293,   1'b0, 32'h0};
        vec[4]  = '{1'b1, 1'b0, 32'h0,   32'h8,     1'b1, 1'b1, 32'h4,   32'h8,   32'h00C2_D293,   1'b0, 32'h0};
        vec[5]  = '{1'b1, 1'b0, 32'h0,   32'h8,     1'b1, 1'b1, 32'h4,   32'h8,   32'h00C2_D293,   1'b0, 32'h0};
        vec[6]  = '{1'b0, 1'b0, 32'h0,   32'hC,     1'b1, 1'b1, 32'h8,   32'hC,   imem(32'h8),     1'b0, 32'h0};
        vec[7]  = '{1'b1, 1'b1, 32'h20,  32'h20,    1'b0, 1'b0, 32'h0,   32'h0,   32'h0,           1'b0, 32'h0};
        vec[8]  = '{1'b0, 1'b0, 32'h0,   32'h24,    1'b1, 1'b1, 32'h20,  32'h24,  32'hFE9F_F0EF,   1'b0, 32'h0};
        vec[9]  = '{1'b0, 1'b1, 32'h4D4, 32'h4D4,   1'b0, 1'b0, 32'h0,   32'h0,   32'h0,           1'b0, 32'h0};
        vec[10] = '{1'b0, 1'b0, 32'h0,   32'h4D8,   1'b1, 1'b1, 32'h4D4, 32'h4D8, imem(32'h4D4),   1'b0, 32'h0};
        vec[11] = '{1'b0, 1'b0, 32'h0,   32'h4D8,   1'b0, 1'b0, 32'h0,   32'h0,   32'h0,           1'b1, 32'h4D8};

        // Reset state
        step();
        step();
        check_reset_state("rst");
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            stall           = vec[i].stall;
            redirect_valid  = vec[i].rv;
            redirect_target = vec[i].tgt;
            step();
            chk($sformatf("v%0d_pc", i), pc, vec[i].pc);
            chk($sformatf("v%0d_vld", i), {31'd0, if_id_valid}, {31'd0, vec[i].vld});
            chk($sformatf("v%0d_fault", i), {31'd0, fetch_fault}, {31'd0, vec[i].fault});
            chk($sformatf("v%0d_fpc", i), fault_pc, vec[i].fpc);
            if (vec[i].chk_if) begin
                chk($sformatf("v%0d_ifpc", i), if_id_pc, vec[i].ifpc);
                chk($sformatf("v%0d_ifpc4", i), if_id_pc_plus4, vec[i].ifpc4);
                chk($sformatf("v%0d_instr", i), if_id_instruction, vec[i].instr);
            end
        end

        // Reset from HALT, with a redirect asserted in the same cycle
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        step();
        check_reset_state("halt_rst");
        reset = 1'b0;
        redirect_valid = 1'b0;
        step();
        chk("resume_e0_pc", pc, 32'h0);
        chk("resume_e0_vld", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("resume_e1_pc", pc, 32'h4);
        chk("resume_e1_vld", {31'd0, if_id_valid}, 32'd1);
        chk("resume_e1_instr", if_id_instruction, 32'h0000_12B7);

        // Misaligned redirect
        redirect_valid  = 1'b1;
        redirect_target = 32'h22;
        step();
        chk("mis_e1_pc", pc, 32'h22);
        chk("mis_e1_fault", {31'd0, fetch_fault}, 32'd0);
        redirect_valid = 1'b0;
        step();
        chk("mis_e2_fault", {31'd0, fetch_fault}, 32'd1);
        chk("mis_e2_fpc", fault_pc, 32'h22);
        chk("mis_e2_vld", {31'd0, if_id_valid}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            redirect_valid  = 1'b1;
            redirect_target = 32'h40 + 32'(k * 4);
            stall           = k[0];
            step();
            chk($sformatf("halt%0d_fault", k), {31'd0, fetch_fault}, 32'd1);
            chk($sformatf("halt%0d_fpc", k), fault_pc, 32'h22);
            chk($sformatf("halt%0d_pc", k), pc, 32'h22);
            chk($sformatf("halt%0d_vld", k), {31'd0, if_id_valid}, 32'd0);
            chk($sformatf("halt%0d_instr", k), if_id_instruction, 32'h0000_12B7);
        end

        // Redirect straight to the first out-of-range word
        reset = 1'b1;
        redirect_valid = 1'b0;
        stall = 1'b0;
        step();
        reset = 1'b0;
        step();
        redirect_valid  = 1'b1;
        redirect_target = 32'h4D8;
        step();
        chk("rng_e1_pc", pc, 32'h4D8);
        chk("rng_e1_fault", {31'd0, fetch_fault}, 32'd0);
        redirect_valid = 1'b0;
        step();
        chk("rng_e2_fault", {31'd0, fetch_fault}, 32'd1);
        chk("rng_e2_fpc", fault_pc, 32'h4D8);
        chk("rng_e2_vld", {31'd0, if_id_valid}, 32'd0);
        chk("rng_e2_pc", pc, 32'h4D8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
